// File: rtl/ctrl_pkg.sv
// ctrl_pkg
//   Shared definitions for the multicycle control sequencer: FSM state
//   encodings, MIPS opcode/funct constants and the instruction-class enum
//   produced by instr_decode.
package ctrl_pkg;

    // State encodings are fixed because they are exported on state_dbg.
    localparam logic [2:0] ST_FETCH  = 3'd0;
    localparam logic [2:0] ST_DECODE = 3'd1;
    localparam logic [2:0] ST_EXEC   = 3'd2;
    localparam logic [2:0] ST_MEM    = 3'd3;
    localparam logic [2:0] ST_WB     = 3'd4;
    localparam logic [2:0] ST_HALT   = 3'd5;

    typedef enum logic [2:0] {
        S_FETCH  = ST_FETCH,
        S_DECODE = ST_DECODE,
        S_EXEC   = ST_EXEC,
        S_MEM    = ST_MEM,
        S_WB     = ST_WB,
        S_HALT   = ST_HALT
    } state_e;

    localparam logic [5:0] OP_RTYPE     = 6'h00;
    localparam logic [5:0] OP_IMM_LO    = 6'h08;
    localparam logic [5:0] OP_IMM_HI    = 6'h0F;
    localparam logic [5:0] OP_LW        = 6'h23;
    localparam logic [5:0] OP_SW        = 6'h2B;
    localparam logic [5:0] FN_JR        = 6'h08;
    localparam logic [5:0] FN_MULDIV_LO = 6'h18;
    localparam logic [5:0] FN_MULDIV_HI = 6'h1B;

    typedef enum logic [2:0] {
        CLS_NOWRITE = 3'd0,
        CLS_RWRITE  = 3'd1,
        CLS_IWRITE  = 3'd2,
        CLS_LW      = 3'd3,
        CLS_SW      = 3'd4
    } instr_class_e;

endpackage

// File: rtl/instr_decode.sv
// instr_decode
//   Purely combinational classifier for the latched instruction.
//   Ports:
//     ir_i         in  32  instruction register contents
//     cls_o        out     instruction class (instr_class_e)
//     dest_zero_o  out  1  destination register of a writing class is $0
module instr_decode
    import ctrl_pkg::*;
(
    input  logic [31:0]  ir_i,
    output instr_class_e cls_o,
    output logic         dest_zero_o
);

    logic [5:0] opcode;
    logic [5:0] funct;
    logic [4:0] rt;
    logic [4:0] rd;
    logic       unused_fields;

    assign opcode = ir_i[31:26];
    assign funct  = ir_i[5:0];
    assign rt     = ir_i[20:16];
    assign rd     = ir_i[15:11];

    // rs and shamt never influence control flow.
    assign unused_fields = ^{ir_i[25:21], ir_i[10:6]};

    always_comb begin
        cls_o       = CLS_NOWRITE;
        dest_zero_o = 1'b0;
        if (opcode == OP_RTYPE) begin
            // JR and MULT/DIV family produce no GPR write.
            if (!(funct == FN_JR ||
                  (funct >= FN_MULDIV_LO && funct <= FN_MULDIV_HI))) begin
                cls_o       = CLS_RWRITE;
                dest_zero_o = (rd == 5'd0);
            end
        end else if (opcode >= OP_IMM_LO && opcode <= OP_IMM_HI) begin
            cls_o       = CLS_IWRITE;
            dest_zero_o = (rt == 5'd0);
        end else if (opcode == OP_LW) begin
            cls_o       = CLS_LW;
            dest_zero_o = (rt == 5'd0);
        end else if (opcode == OP_SW) begin
            cls_o       = CLS_SW;
        end
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl
//   Multicycle control sequencer for the MIPS CPU. Latches one instruction
//   per fetch handshake and walks it through DECODE/EXEC/MEM/WB, stalling on
//   alu_busy (EXEC) and mem_waitrequest (MEM); stops for good on HALT_INSTR.
//
//   state  | meaning
//   FETCH  | instr_ready high, waiting for a transfer
//   DECODE | one-cycle register-file read (rf_active)
//   EXEC   | alu_start on entry, wait for alu_busy low, pick next stage
//   MEM    | mem_read/mem_write held until mem_waitrequest low
//   WB     | one-cycle register write (rf_w_en) and pc_advance
//   HALT   | terminal; only reset leaves
//
//   Ports: clk, reset (async, active low); fetch handshake instr_valid /
//   instr_ready / instruction; ir_out; stall inputs alu_busy,
//   mem_waitrequest; strobes ir_load, rf_active, rf_w_en, rf_reg_dst,
//   wb_sel, alu_start, mem_read, mem_write, pc_advance; halted, state_dbg.
module multicycle_ctrl
    import ctrl_pkg::*;
#(
    parameter logic [31:0] HALT_INSTR = 32'h0000_0008
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        instr_valid,
    output logic        instr_ready,
    input  logic [31:0] instruction,
    output logic [31:0] ir_out,
    input  logic        alu_busy,
    input  logic        mem_waitrequest,
    output logic        ir_load,
    output logic        rf_active,
    output logic        rf_w_en,
    output logic        rf_reg_dst,
    output logic        wb_sel,
    output logic        alu_start,
    output logic        mem_read,
    output logic        mem_write,
    output logic        pc_advance,
    output logic        halted,
    output logic [2:0]  state_dbg
);

    logic [2:0]   state_q, state_d;
    logic [31:0]  ir_q, ir_d;
    // Marks the first EXEC cycle so alu_start fires once even when stalled.
    logic         exec_entry_q, exec_entry_d;
    instr_class_e cls;
    logic         dest_zero;
    logic         writes_gpr;

    instr_decode u_decode (
        .ir_i        (ir_q),
        .cls_o       (cls),
        .dest_zero_o (dest_zero)
    );

    assign writes_gpr = ((cls == CLS_RWRITE) || (cls == CLS_IWRITE)) && !dest_zero;

    always_comb begin
        state_d      = state_q;
        ir_d         = ir_q;
        exec_entry_d = 1'b0;
        instr_ready  = 1'b0;
        ir_load      = 1'b0;
        rf_active    = 1'b0;
        rf_w_en      = 1'b0;
        rf_reg_dst   = 1'b0;
        wb_sel       = 1'b0;
        alu_start    = 1'b0;
        mem_read     = 1'b0;
        mem_write    = 1'b0;
        pc_advance   = 1'b0;
        halted       = 1'b0;

        case (state_q)
            ST_FETCH: begin
                instr_ready = 1'b1;
                if (instr_valid) begin
                    ir_load = 1'b1;
                    ir_d    = instruction;
                    state_d = ST_DECODE;
                end
            end
            ST_DECODE: begin
                rf_active    = 1'b1;
                exec_entry_d = 1'b1;
                state_d      = ST_EXEC;
            end
            ST_EXEC: begin
                alu_start = exec_entry_q;
                if (!alu_busy) begin
                    // Halt check comes first: JR $0 would otherwise decode as no-write.
                    if (ir_q == HALT_INSTR) begin
                        state_d = ST_HALT;
                    end else if ((cls == CLS_LW) || (cls == CLS_SW)) begin
                        state_d = ST_MEM;
                    end else if (writes_gpr) begin
                        state_d = ST_WB;
                    end else begin
                        state_d    = ST_FETCH;
                        pc_advance = 1'b1;
                    end
                end
            end
            ST_MEM: begin
                mem_read  = (cls == CLS_LW);
                mem_write = (cls == CLS_SW);
                if (!mem_waitrequest) begin
                    if ((cls == CLS_LW) && !dest_zero) begin
                        state_d = ST_WB;
                    end else begin
                        state_d    = ST_FETCH;
                        pc_advance = 1'b1;
                    end
                end
            end
            ST_WB: begin
                rf_w_en    = 1'b1;
                pc_advance = 1'b1;
                rf_reg_dst = (cls == CLS_RWRITE);
                wb_sel     = (cls == CLS_LW);
                state_d    = ST_FETCH;
            end
            ST_HALT: begin
                halted = 1'b1;
            end
            default: begin
                state_d = ST_FETCH;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_FETCH;
            ir_q         <= 32'd0;
            exec_entry_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            ir_q         <= ir_d;
            exec_entry_q <= exec_entry_d;
        end
    end

    assign ir_out    = ir_q;
    assign state_dbg = state_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl
//   Directed-vector bench for multicycle_ctrl. Each step drives inputs,
//   compares state_dbg and the packed strobe vector to hand-computed values,
//   then advances one clock.
module tb_multicycle_ctrl;

    localparam logic [10:0] RDY = 11'h400;
    localparam logic [10:0] LD  = 11'h200;
    localparam logic [10:0] RA  = 11'h100;
    localparam logic [10:0] WE  = 11'h080;
    localparam logic [10:0] DST = 11'h040;
    localparam logic [10:0] WBS = 11'h020;
    localparam logic [10:0] AS  = 11'h010;
    localparam logic [10:0] MR  = 11'h008;
    localparam logic [10:0] MW  = 11'h004;
    localparam logic [10:0] PC  = 11'h002;
    localparam logic [10:0] HL  = 11'h001;
    localparam logic [10:0] NONE = 11'h000;

    localparam logic [31:0] I_ADDU  = 32'h0022_1821;
    localparam logic [31:0] I_LW    = 32'h8C25_0004;
    localparam logic [31:0] I_MULT  = 32'h0022_0018;
    localparam logic [31:0] I_ADDIU = 32'h2420_0005;
    localparam logic [31:0] I_SW    = 32'hAC25_0004;
    localparam logic [31:0] I_HALT  = 32'h0000_0008;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        instr_valid = 1'b0;
    logic        instr_ready;
    logic [31:0] instruction = 32'd0;
    logic [31:0] ir_out;
    logic        alu_busy = 1'b0;
    logic        mem_waitrequest = 1'b0;
    logic        ir_load, rf_active, rf_w_en, rf_reg_dst, wb_sel;
    logic        alu_start, mem_read, mem_write, pc_advance, halted;
    logic [2:0]  state_dbg;
    logic [10:0] strobes;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    multicycle_ctrl dut (
        .clk             (clk),
        .reset           (reset),
        .instr_valid     (instr_valid),
        .instr_ready     (instr_ready),
        .instruction     (instruction),
        .ir_out          (ir_out),
        .alu_busy        (alu_busy),
        .mem_waitrequest (mem_waitrequest),
        .ir_load         (ir_load),
        .rf_active       (rf_active),
        .rf_w_en         (rf_w_en),
        .rf_reg_dst      (rf_reg_dst),
        .wb_sel          (wb_sel),
        .alu_start       (alu_start),
        .mem_read        (mem_read),
        .mem_write       (mem_write),
        .pc_advance      (pc_advance),
        .halted          (halted),
        .state_dbg       (state_dbg)
    );

    assign strobes = {instr_ready, ir_load, rf_active, rf_w_en, rf_reg_dst,
                      wb_sel, alu_start, mem_read, mem_write, pc_advance, halted};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Inputs are already set by the caller; sample mid-cycle, then clock.
    task automatic step(input string tag, input logic [2:0] st, input logic [10:0] strb);
        #1;
        check({tag, ".state"}, {29'd0, state_dbg}, {29'd0, st});
        check({tag, ".strb"}, {21'd0, strobes}, {21'd0, strb});
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset state.
        repeat (2) @(posedge clk);
        #1;
        check("rst.state", {29'd0, state_dbg}, 32'd0);
        check("rst.strb", {21'd0, strobes}, {21'd0, RDY});
        check("rst.ir", ir_out, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;

        // ADDU $3,$1,$2 with instr_valid held; new instruction word during
        // DECODE must not reach the IR.
        instr_valid = 1'b1;
        instruction = I_ADDU;
        step("addu.c0", 3'd0, RDY | LD);
        instruction = 32'hFFFF_FFFF;
        step("addu.c1", 3'd1, RA);
        check("addu.ir", ir_out, I_ADDU);
        step("addu.c2", 3'd2, AS);
        step("addu.c3", 3'd4, WE | DST | PC);
        check("addu.ir_hold", ir_out, I_ADDU);

        // LW $5,4($1): waitrequest raised early (ignored in EXEC), 2 MEM waits.
        instruction = I_LW;
        step("lw.c0", 3'd0, RDY | LD);
        instr_valid = 1'b0;
        mem_waitrequest = 1'b1;
        step("lw.c1", 3'd1, RA);
        step("lw.c2", 3'd2, AS);
        alu_busy = 1'b1;
        step("lw.c3", 3'd3, MR);
        step("lw.c4", 3'd3, MR);
        mem_waitrequest = 1'b0;
        alu_busy = 1'b0;
        step("lw.c5", 3'd3, MR);
        step("lw.c6", 3'd4, WE | WBS | PC);
        check("lw.ir", ir_out, I_LW);

        // MULT with alu_busy high for the first 3 EXEC cycles.
        instr_valid = 1'b1;
        instruction = I_MULT;
        step("mult.c0", 3'd0, RDY | LD);
        instr_valid = 1'b0;
        alu_busy = 1'b1;
        step("mult.c1", 3'd1, RA);
        step("mult.c2", 3'd2, AS);
        step("mult.c3", 3'd2, NONE);
        step("mult.c4", 3'd2, NONE);
        alu_busy = 1'b0;
        step("mult.c5", 3'd2, PC);

        // ADDIU $0,$1,5: destination $0 skips WB.
        instr_valid = 1'b1;
        instruction = I_ADDIU;
        step("addiu.c0", 3'd0, RDY | LD);
        instr_valid = 1'b0;
        step("addiu.c1", 3'd1, RA);
        step("addiu.c2", 3'd2, AS | PC);

        // SW without waits: one MEM cycle.
        instr_valid = 1'b1;
        instruction = I_SW;
        step("sw.c0", 3'd0, RDY | LD);
        instr_valid = 1'b0;
        step("sw.c1", 3'd1, RA);
        step("sw.c2", 3'd2, AS);
        step("sw.c3", 3'd3, MW | PC);
        step("sw.c4", 3'd0, RDY);

        // SW aborted by reset while stalled in MEM.
        instr_valid = 1'b1;
        instruction = I_SW;
        step("swr.c0", 3'd0, RDY | LD);
        instr_valid = 1'b0;
        step("swr.c1", 3'd1, RA);
        step("swr.c2", 3'd2, AS);
        mem_waitrequest = 1'b1;
        #1;
        check("swr.mem_write", {31'd0, mem_write}, 32'd1);
        #1;
        reset = 1'b0;
        #1;
        check("swr.async_mw", {31'd0, mem_write}, 32'd0);
        check("swr.async_st", {29'd0, state_dbg}, 32'd0);
        check("swr.async_rdy", {31'd0, instr_ready}, 32'd1);
        check("swr.async_ir", ir_out, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        mem_waitrequest = 1'b0;
        @(posedge clk);
        #1;
        step("swr.after", 3'd0, RDY);

        // Halt instruction; instr_valid kept high afterwards.
        instr_valid = 1'b1;
        instruction = I_HALT;
        step("halt.c0", 3'd0, RDY | LD);
        step("halt.c1", 3'd1, RA);
        step("halt.c2", 3'd2, AS);
        for (int i = 0; i < 20; i++) begin
            step($sformatf("halt.h%0d", i), 3'd5, HL);
        end
        check("halt.ir", ir_out, I_HALT);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
